// File: rtl/alu_pkg.sv
// Shared opcode and state types for the sequential ALU, plus opcode classification helpers.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_AND  = 4'b0000,
        OP_OR   = 4'b0001,
        OP_ADD  = 4'b0010,
        OP_SUB  = 4'b0110,
        OP_SLT  = 4'b0111,
        OP_MUL  = 4'b1000,
        OP_DIV  = 4'b1010,
        OP_DIVU = 4'b1011,
        OP_REM  = 4'b1100,
        OP_REMU = 4'b1101
    } alu_op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIX,
        ST_DONE
    } alu_state_t;

    function automatic logic is_multicycle(alu_op_t op);
        return op inside {OP_MUL, OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic logic is_signed_div(alu_op_t op);
        return op inside {OP_DIV, OP_REM};
    endfunction

    function automatic logic is_rem(alu_op_t op);
        return op inside {OP_REM, OP_REMU};
    endfunction

endpackage

// File: rtl/alu_seq_muldiv_step.sv
// One iteration of MSB-first shift-add multiply (mode=0) or restoring divide (mode=1).
module muldiv_step #(
    parameter int N = 64
) (
    input  logic [N-1:0] acc,
    input  logic [N-1:0] opr,
    input  logic [N-1:0] arg,
    input  logic         mode,
    output logic [N-1:0] acc_next,
    output logic [N-1:0] opr_next
);

    logic [N:0] shifted;
    logic [N:0] diff;

    // Divide: acc is the partial remainder, opr shifts dividend bits out and quotient bits in.
    // Multiply: acc is the product so far, opr shifts multiplier bits out MSB first.
    always_comb begin
        shifted  = {acc, opr[N-1]};
        diff     = shifted - {1'b0, arg};
        acc_next = '0;
        opr_next = '0;
        if (mode) begin
            if (!diff[N]) begin
                acc_next = diff[N-1:0];
                opr_next = {opr[N-2:0], 1'b1};
            end else begin
                acc_next = shifted[N-1:0];
                opr_next = {opr[N-2:0], 1'b0};
            end
        end else begin
            acc_next = {acc[N-2:0], 1'b0} + (opr[N-1] ? arg : '0);
            opr_next = {opr[N-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked execute-stage ALU: single-cycle logic/arith ops plus iterative mul/div/rem.
module alu_seq
    import alu_pkg::*;
#(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [3:0]   ALUControl,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic         zero
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] CNT_INIT = CW'(N - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [N-1:0]  MOST_NEG = {1'b1, {(N-1){1'b0}}};

    alu_state_t    state_reg;
    logic [CW-1:0] cnt_reg;
    logic [N-1:0]  acc_reg, opr_reg, arg_reg;
    alu_op_t       op_reg;
    logic          neg_q_reg, neg_r_reg;
    logic [N-1:0]  result_reg;
    logic          zero_reg;

    alu_op_t       op_in;
    logic          accept, b_zero, ovf, special, iterate, is_mul;
    logic          a_neg, b_neg;
    logic [N-1:0]  abs_a, abs_b, quick, fix_val;
    logic [N-1:0]  s_acc, s_opr, s_arg, step_acc, step_opr;
    logic          s_mode;

    assign op_in     = alu_op_t'(ALUControl);
    assign in_ready  = (state_reg == ST_IDLE) | ((state_reg == ST_DONE) & out_ready);
    assign out_valid = (state_reg == ST_DONE);
    assign accept    = in_valid & in_ready;
    assign result    = result_reg;
    assign zero      = zero_reg;

    assign is_mul  = (op_in == OP_MUL);
    assign b_zero  = (b == '0);
    assign ovf     = is_signed_div(op_in) & (a == MOST_NEG) & (b == '1);
    assign special = is_multicycle(op_in) & !is_mul & (b_zero | ovf);
    assign iterate = is_multicycle(op_in) & !special;
    assign a_neg   = is_signed_div(op_in) & a[N-1];
    assign b_neg   = is_signed_div(op_in) & b[N-1];
    assign abs_a   = a_neg ? -a : a;
    assign abs_b   = b_neg ? -b : b;

    // Single-cycle results, including the div-by-zero and signed-overflow bypasses.
    always_comb begin
        quick = b;
        case (op_in)
            OP_AND:           quick = a & b;
            OP_OR:            quick = a | b;
            OP_ADD:           quick = a + b;
            OP_SUB:           quick = a - b;
            OP_SLT:           quick = {{(N-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_DIV, OP_DIVU:  quick = b_zero ? '1 : a;
            OP_REM, OP_REMU:  quick = b_zero ? a : '0;
            default:          quick = b;
        endcase
    end

    // The first iteration rides on the accept edge, so mul/div reach DONE N+1 cycles later.
    always_comb begin
        if (state_reg == ST_MUL || state_reg == ST_DIV) begin
            s_acc  = acc_reg;
            s_opr  = opr_reg;
            s_arg  = arg_reg;
            s_mode = (state_reg == ST_DIV);
        end else begin
            s_acc  = '0;
            s_opr  = is_mul ? b : abs_a;
            s_arg  = is_mul ? a : abs_b;
            s_mode = !is_mul;
        end
    end

    muldiv_step #(.N(N)) u_step (
        .acc      (s_acc),
        .opr      (s_opr),
        .arg      (s_arg),
        .mode     (s_mode),
        .acc_next (step_acc),
        .opr_next (step_opr)
    );

    always_comb begin
        if (op_reg == OP_MUL)
            fix_val = acc_reg;
        else if (is_rem(op_reg))
            fix_val = neg_r_reg ? -acc_reg : acc_reg;
        else
            fix_val = neg_q_reg ? -opr_reg : opr_reg;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= '0;
            acc_reg    <= '0;
            opr_reg    <= '0;
            arg_reg    <= '0;
            op_reg     <= OP_AND;
            neg_q_reg  <= 1'b0;
            neg_r_reg  <= 1'b0;
            result_reg <= '0;
            zero_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_MUL, ST_DIV: begin
                    acc_reg <= step_acc;
                    opr_reg <= step_opr;
                    cnt_reg <= cnt_reg - 1'b1;
                    if (cnt_reg == CNT_ONE)
                        state_reg <= ST_FIX;
                end
                ST_FIX: begin
                    result_reg <= fix_val;
                    zero_reg   <= (fix_val == '0);
                    state_reg  <= ST_DONE;
                end
                default: begin
                    if (accept) begin
                        op_reg <= op_in;
                        if (iterate) begin
                            state_reg <= is_mul ? ST_MUL : ST_DIV;
                            cnt_reg   <= CNT_INIT;
                            acc_reg   <= step_acc;
                            opr_reg   <= step_opr;
                            arg_reg   <= s_arg;
                            neg_q_reg <= a_neg ^ b_neg;
                            neg_r_reg <= a_neg;
                        end else begin
                            result_reg <= quick;
                            zero_reg   <= (quick == '0);
                            state_reg  <= ST_DONE;
                        end
                    end else if (state_reg == ST_DONE && out_ready) begin
                        state_reg <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Randomised scoreboard bench for alu_seq (N=8) plus a wide-operand multiply check (N=64).
`timescale 1ns/1ps
module tb_alu_seq;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, out_valid, out_ready, zero;
    logic [N-1:0] a, b, result;
    logic [3:0]   alu_ctl;

    logic         in_valid64, in_ready64, out_valid64, out_ready64, zero64;
    logic [63:0]  a64, b64, result64;
    logic [3:0]   ctl64;

    always #5 clk = ~clk;

    alu_seq #(.N(N)) dut (
        .clk        (clk),
        .reset      (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .ALUControl (alu_ctl),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .zero       (zero)
    );

    alu_seq #(.N(64)) dut64 (
        .clk        (clk),
        .reset      (rst),
        .in_valid   (in_valid64),
        .in_ready   (in_ready64),
        .a          (a64),
        .b          (b64),
        .ALUControl (ctl64),
        .out_valid  (out_valid64),
        .out_ready  (out_ready64),
        .result     (result64),
        .zero       (zero64)
    );

    typedef struct {
        logic [3:0]   op;
        logic [N-1:0] x;
        logic [N-1:0] y;
        logic [N-1:0] res;
        logic         z;
        int           acc_cyc;
        int           lat;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   bp_mode = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference behaviour straight from the opcode table, using native integer arithmetic.
    function automatic logic [N-1:0] model(input logic [3:0] op, input logic [N-1:0] x, input logic [N-1:0] y);
        int sx, sy, ux, uy, r;
        sx = $signed(x);
        sy = $signed(y);
        ux = int'(x);
        uy = int'(y);
        case (op)
            4'b0000: r = ux & uy;
            4'b0001: r = ux | uy;
            4'b0010: r = ux + uy;
            4'b0110: r = ux - uy;
            4'b0111: r = (sx < sy) ? 1 : 0;
            4'b1000: r = ux * uy;
            4'b1010: r = (sy == 0) ? -1 : sx / sy;
            4'b1011: r = (uy == 0) ? -1 : ux / uy;
            4'b1100: r = (sy == 0) ? sx : sx % sy;
            4'b1101: r = (uy == 0) ? ux : ux % uy;
            default: r = uy;
        endcase
        return r[N-1:0];
    endfunction

    function automatic int model_lat(input logic [3:0] op, input logic [N-1:0] x, input logic [N-1:0] y);
        int sx, sy;
        sx = $signed(x);
        sy = $signed(y);
        if (op == 4'b1000) return N + 1;
        if (op inside {4'b1010, 4'b1011, 4'b1100, 4'b1101}) begin
            if (y == 0) return 1;
            if ((op == 4'b1010 || op == 4'b1100) && sx == -(1 << (N-1)) && sy == -1) return 1;
            return N + 1;
        end
        return 1;
    endfunction

    // Back-pressure driver: 0 = always ready, 1 = random, 2 = held low.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (bp_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Scoreboard push: record expectation in the cycle the handshake is seen.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!rst && in_valid && in_ready) begin
            e.op      = alu_ctl;
            e.x       = a;
            e.y       = b;
            e.res     = model(alu_ctl, a, b);
            e.z       = (e.res == 0);
            e.acc_cyc = cyc;
            e.lat     = model_lat(alu_ctl, a, b);
            exp_q.push_back(e);
        end
    end

    // Monitor: latency on first appearance, value on transfer, stability while stalled.
    initial begin
        logic         seen, stalled, held_z;
        logic [N-1:0] held_res;
        seen = 0;
        stalled = 0;
        held_z = 0;
        held_res = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                seen = 0;
                stalled = 0;
            end else begin
                if (stalled) begin
                    chk("stall_out_valid", out_valid, 1);
                    chk("stall_result", result, held_res);
                    chk("stall_zero", zero, held_z);
                end
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_output: result 0x%0h with empty scoreboard (t=%0t)", result, $time);
                    end else begin
                        if (!seen) begin
                            chk("latency", cyc - exp_q[0].acc_cyc, exp_q[0].lat);
                            seen = 1;
                        end
                        if (out_ready) begin
                            chk("result", result, exp_q[0].res);
                            chk("zero", zero, exp_q[0].z);
                            $display("txn op=%b a=%02h b=%02h result=%02h zero=%0b", exp_q[0].op,
                                     exp_q[0].x, exp_q[0].y, result, zero);
                            void'(exp_q.pop_front());
                            seen = 0;
                        end
                    end
                end
                if (out_valid && !out_ready) begin
                    chk("stall_in_ready", in_ready, 0);
                    stalled = 1;
                    held_res = result;
                    held_z = zero;
                end else begin
                    stalled = 0;
                end
            end
        end
    end

    task automatic send(input logic [3:0] op, input logic [N-1:0] x, input logic [N-1:0] y);
        int waited = 0;
        alu_ctl = op;
        a = x;
        b = y;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: op=%b never accepted", op);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = N'($urandom);
        b = N'($urandom);
        alu_ctl = 4'($urandom);
    endtask

    task automatic drain();
        int waited = 0;
        while (exp_q.size() != 0 && waited < 300) begin
            @(posedge clk);
            waited++;
        end
        #1;
        chk("drain_pending", exp_q.size(), 0);
    endtask

    task automatic wait_valid();
        int waited = 0;
        @(negedge clk);
        while (!out_valid && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        chk("wait_valid", out_valid, 1);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    localparam logic [3:0] OPS [12] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1000,
                                        4'b1010, 4'b1011, 4'b1100, 4'b1101, 4'b0011, 4'b1111};

    initial begin
        int lat;
        logic [3:0]   op;
        logic [N-1:0] x, y;

        rst = 1'b1;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        alu_ctl = '0;
        in_valid64 = 1'b0;
        a64 = '0;
        b64 = '0;
        ctl64 = '0;
        out_ready64 = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_result", result, 0);
        chk("reset_zero", zero, 0);
        chk("reset_out_valid64", out_valid64, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("in_ready_after_reset", in_ready, 1);

        send(4'b0010, 8'h7F, 8'h01);
        send(4'b0110, 8'h55, 8'h55);
        send(4'b1000, 8'd13, 8'd11);
        send(4'b1010, 8'hF9, 8'h02);
        send(4'b1100, 8'hF9, 8'h02);
        send(4'b1011, 8'hF9, 8'h02);
        send(4'b1101, 8'hF9, 8'h02);
        send(4'b1011, 8'h05, 8'h00);
        send(4'b1101, 8'h05, 8'h00);
        send(4'b1010, 8'h80, 8'hFF);
        send(4'b1100, 8'h80, 8'hFF);
        drain();

        // Hold a MUL result for three cycles while an ADD waits, then release.
        bp_mode = 2;
        send(4'b1000, 8'd13, 8'd11);
        fork
            send(4'b0010, 8'h10, 8'h20);
            begin
                wait_valid();
                repeat (3) @(posedge clk);
                #1;
                bp_mode = 0;
            end
        join
        drain();

        // Reset during the fourth MUL cycle; the op must vanish.
        send(4'b1000, 8'h37, 8'h5A);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        #1;
        chk("midreset_out_valid", out_valid, 0);
        chk("midreset_result", result, 0);
        chk("midreset_zero", zero, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("postreset_in_ready", in_ready, 1);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("postreset_no_output", out_valid, 0);
        end
        @(posedge clk);
        #1;
        send(4'b0010, 8'h21, 8'h12);
        drain();

        bp_mode = 1;
        for (int i = 0; i < 300; i++) begin
            op = OPS[$urandom_range(0, 11)];
            x = N'($urandom);
            y = N'($urandom);
            if ($urandom_range(0, 7) == 0) y = '0;
            if ($urandom_range(0, 15) == 0) begin
                x = 8'h80;
                y = 8'hFF;
            end
            send(op, x, y);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        drain();
        bp_mode = 0;

        // Wide multiply: 2^32 * 2^32 wraps to zero in 64 bits.
        a64 = 64'h0000_0001_0000_0000;
        b64 = 64'h0000_0001_0000_0000;
        ctl64 = 4'b1000;
        in_valid64 = 1'b1;
        @(negedge clk);
        chk("n64_in_ready", in_ready64, 1);
        lat = cyc;
        @(posedge clk);
        #1;
        in_valid64 = 1'b0;
        a64 = 64'hDEAD_BEEF_0123_4567;
        for (int w = 0; w < 200; w++) begin
            @(negedge clk);
            if (out_valid64) break;
        end
        chk("n64_out_valid", out_valid64, 1);
        chk("n64_latency", cyc - lat, 65);
        chk("n64_result", result64, 64'h0);
        chk("n64_zero", zero64, 1);
        $display("txn n64 op=1000 a=100000000 b=100000000 result=%0h zero=%0b", result64, zero64);

        @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
